riscv_hazard_forward_unit: RTL
==============================

// Module: riscv_hazard_forward_unit
// PURPOSE
//  Central hazard controller for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB).
//  Tracks in-flight destination registers and generates ALU-operand forwarding selects.
//  Also generates load-use stalls, multi-cycle data-memory freezes, and branch/jump flushes.
//  Sits beside the pipe registers; drives their stall/flush/bubble controls and the EX operand muxes.
// PARAMETERS
//  REG_ADDR_W  5   register index width (32 architectural registers)
//  LOAD_LAT    1   data-memory read latency in cycles, >=1; >1 freezes the whole pipe
//  FWD_EN      1   1: forwarding active; 0: selects forced to 00, RAW resolved by stalling
//  CNT_W       16  width of the saturating performance counters
// PORTS
//  clk             in   1           core clock
//  reset           in   1           asynchronous, active-high
//  id_rs1_i        in   REG_ADDR_W  rs1 of the instruction in ID
//  id_rs2_i        in   REG_ADDR_W  rs2 of the instruction in ID
//  id_use_rs1_i    in   1           ID instruction reads rs1
//  id_use_rs2_i    in   1           ID instruction reads rs2
//  id_rd_i         in   REG_ADDR_W  rd of the instruction in ID
//  id_reg_write_i  in   1           ID instruction writes rd
//  id_mem_read_i   in   1           ID instruction is a load
//  ex_redirect_i   in   1           taken branch / jal / jalr resolved in EX
//  pc_stall_o      out  1           hold PC
//  if_id_stall_o   out  1           hold IF/ID
//  if_id_flush_o   out  1           clear IF/ID to NOP
//  id_ex_bubble_o  out  1           load NOP (all control 0) into ID/EX
//  pipe_freeze_o   out  1           hold ID/EX, EX/MEM and MEM/WB (memory wait)
//  fwd_a_sel_o     out  2           EX operand A: 00 regfile, 01 EX/MEM result, 10 MEM/WB wb data
//  fwd_b_sel_o     out  2           EX operand B: same encoding
//  stall_cnt_o     out  CNT_W       cycles with pc_stall_o=1, saturating
//  flush_cnt_o     out  CNT_W       redirects taken, saturating
// BEHAVIOUR
//  - Reset: all outputs 0, shadow stage registers invalid, FSM=RUN, counters 0.
//  - Shadow regs: {rd, reg_write, mem_read, rs1, rs2} for EX, MEM and WB.
//    - Each shifts one stage per cycle while pipe_freeze_o=0.
//    - EX shadow loads the ID inputs, or zeros when id_ex_bubble_o=1.
//  - rd==0 never matches: no forward and no stall.
//  - Forward (combinational from shadows, EX instruction):
//    - EX.rs==MEM.rd with MEM.reg_write and !MEM.mem_read -> 01.
//    - Else EX.rs==WB.rd with WB.reg_write -> 10.
//    - Else 00. MEM has priority over WB.
//  - Load-use: EX.mem_read, EX.rd!=0, and (EX.rd==id_rs1 & use_rs1 | EX.rd==id_rs2 & use_rs2).
//    - Response: pc_stall=if_id_stall=id_ex_bubble=1 for exactly 1 cycle.
//  - FWD_EN=0: any ID source matching EX/MEM/WB rd with reg_write stalls as for load-use, until clear.
//  - FSM states: RUN, MEM_WAIT.
//    - RUN->MEM_WAIT when the MEM shadow holds a load and LOAD_LAT>1.
//    - MEM_WAIT: counter runs LOAD_LAT-1 cycles; pipe_freeze=pc_stall=if_id_stall=1; then back to RUN.
//    - LOAD_LAT=1: never leaves RUN.
//  - Redirect is sampled only when pipe_freeze_o=0.
//    - Response: if_id_flush=id_ex_bubble=1 in the same cycle.
//    - Redirect overrides a coincident load-use stall: pc_stall=if_id_stall=0, the wrong-path instruction is killed.
//  - Simultaneous MEM_WAIT and redirect: freeze wins; redirect is held by the EX stage and acted on the first unfrozen cycle.
//  - Counters saturate at all-ones and never wrap.
//  - Reset mid-MEM_WAIT: immediate return to RUN, all outputs 0.
// STRUCTURE
//  - Shared package riscv_pipe_pkg:
//    - FWD_REGFILE/FWD_EXMEM/FWD_MEMWB encodings;
//    - FSM state encoding;
//    - REG_ADDR_W default.
//  - One sub-module, sat_counter #(CNT_W): inc, clear, value; instantiated twice.
//  - Shadow pipeline and FSM are local to this module.
// TESTING
//  1 add x5,x1,x2 ; add x6,x5,x3 -> fwd_a_sel=01 in the 2nd instr's EX cycle, no stall.
//  2 add x5,.. ; nop ; sub x7,x5,x5 -> fwd_a_sel=fwd_b_sel=10, stall_cnt stays 0.
//  3 lw x8,0(x0) ; add x9,x8,x1 -> 1-cycle pc_stall+bubble, then fwd_a_sel=10; stall_cnt=1.
//  4 LOAD_LAT=3, lw followed by independent adds -> pipe_freeze high exactly 2 cycles.
//  5 redirect coincident with a load-use stall -> flush+bubble, pc_stall=0, flush_cnt=1.
//  6 addi x0,x0,1 ; add x1,x0,x0 -> sel=00; assert reset mid-MEM_WAIT -> outputs 0 the same cycle.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the 5-stage pipeline hazard/forwarding logic.
package riscv_pipe_pkg;

   // Default register index width (32 architectural registers)
   localparam int REG_ADDR_W_DEF = 5;

   // EX operand mux selects
   localparam logic [1:0] FWD_REGFILE = 2'b00;
   localparam logic [1:0] FWD_EXMEM   = 2'b01;
   localparam logic [1:0] FWD_MEMWB   = 2'b10;

   // Hazard controller FSM
   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } hz_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones, never wraps.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc_i,
   input  logic             clear_i,
   output logic [CNT_W-1:0] value_o
);

   logic [CNT_W-1:0] cnt_q;

   // Count events; clear has priority, hold once saturated
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                          cnt_q <= '0;
      else if (clear_i)                   cnt_q <= '0;
      else if (inc_i && (cnt_q != '1))   cnt_q <= cnt_q + 1'b1;
   end

   assign value_o = cnt_q;

endmodule

// File: rtl/riscv_hazard_forward_unit.sv
// Hazard controller for the IF/ID/EX/MEM/WB pipeline: shadows the in-flight
// register usage of EX/MEM/WB, drives the EX operand forwarding selects and the
// stall / flush / bubble / freeze controls of the pipe registers.
module riscv_hazard_forward_unit
   import riscv_pipe_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int LOAD_LAT   = 1,
   parameter int FWD_EN     = 1,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] id_rs1_i,
   input  logic [REG_ADDR_W-1:0] id_rs2_i,
   input  logic                  id_use_rs1_i,
   input  logic                  id_use_rs2_i,
   input  logic [REG_ADDR_W-1:0] id_rd_i,
   input  logic                  id_reg_write_i,
   input  logic                  id_mem_read_i,
   input  logic                  ex_redirect_i,
   output logic                  pc_stall_o,
   output logic                  if_id_stall_o,
   output logic                  if_id_flush_o,
   output logic                  id_ex_bubble_o,
   output logic                  pipe_freeze_o,
   output logic [1:0]            fwd_a_sel_o,
   output logic [1:0]            fwd_b_sel_o,
   output logic [CNT_W-1:0]      stall_cnt_o,
   output logic [CNT_W-1:0]      flush_cnt_o
);

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic                  reg_write;
      logic                  mem_read;
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
   } shadow_t;

   // Wait counter counts 0 .. LOAD_LAT-2 while in MEM_WAIT
   localparam int WAIT_W = (LOAD_LAT > 2) ? $clog2(LOAD_LAT - 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((LOAD_LAT > 1) ? (LOAD_LAT - 2) : 0);

   shadow_t            id_s, ex_q, mem_q, wb_q;
   hz_state_e          state_q, state_d;
   logic [WAIT_W-1:0]  wcnt_q, wcnt_d;
   logic               frz, redir, load_use, raw_any, hazard;

   // Source rs is produced by shadow s (x0 is never a producer)
   function automatic logic hits(input logic [REG_ADDR_W-1:0] rs, input logic use_rs,
                                 input shadow_t s);
      return use_rs && (rs != '0) && s.reg_write && (s.rd == rs);
   endfunction

   // MEM beats WB; a load in MEM has no data yet, so it never forwards
   function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs,
                                          input shadow_t mem_s, input shadow_t wb_s);
      logic [1:0] sel;
      sel = FWD_REGFILE;
      if ((rs != '0) && mem_s.reg_write && !mem_s.mem_read && (mem_s.rd == rs))
         sel = FWD_EXMEM;
      else if ((rs != '0) && wb_s.reg_write && (wb_s.rd == rs))
         sel = FWD_MEMWB;
      return sel;
   endfunction

   assign id_s = '{rd: id_rd_i, reg_write: id_reg_write_i, mem_read: id_mem_read_i,
                   rs1: id_rs1_i, rs2: id_rs2_i};

   assign frz = (state_q == ST_MEM_WAIT);
   // A redirect during a freeze stays parked in EX and is seen once unfrozen
   assign redir = ex_redirect_i && !frz && !reset;

   assign load_use = ex_q.mem_read && (ex_q.rd != '0) &&
                     ((id_use_rs1_i && (ex_q.rd == id_rs1_i)) ||
                      (id_use_rs2_i && (ex_q.rd == id_rs2_i)));

   assign raw_any = hits(id_rs1_i, id_use_rs1_i, ex_q)  || hits(id_rs2_i, id_use_rs2_i, ex_q)  ||
                    hits(id_rs1_i, id_use_rs1_i, mem_q) || hits(id_rs2_i, id_use_rs2_i, mem_q) ||
                    hits(id_rs1_i, id_use_rs1_i, wb_q)  || hits(id_rs2_i, id_use_rs2_i, wb_q);

   assign hazard = load_use || ((FWD_EN == 0) && raw_any);

   // Redirect kills the wrong-path ID instruction, so it cancels any RAW stall
   assign pc_stall_o     = frz || (hazard && !redir);
   assign if_id_stall_o  = frz || (hazard && !redir);
   assign if_id_flush_o  = redir;
   assign id_ex_bubble_o = !frz && (redir || hazard);
   assign pipe_freeze_o  = frz;

   assign fwd_a_sel_o = (FWD_EN != 0) ? fwd_sel(ex_q.rs1, mem_q, wb_q) : FWD_REGFILE;
   assign fwd_b_sel_o = (FWD_EN != 0) ? fwd_sel(ex_q.rs2, mem_q, wb_q) : FWD_REGFILE;

   // Shadow pipeline advances with the real pipe; bubbles enter as all-zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else if (!frz) begin
         wb_q  <= mem_q;
         mem_q <= ex_q;
         ex_q  <= id_ewb_sel(id_ex_bubble_o, id_s);
      end
   end

   function automatic shadow_t id_ewb_sel(input logic bubble, input shadow_t s);
      return bubble ? shadow_t'('0) : s;
   endfunction

   // FSM state and wait counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_RUN;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
      end
   end

   // Load reaching MEM with a multi-cycle memory freezes the pipe LOAD_LAT-1 cycles
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         ST_RUN: begin
            if ((LOAD_LAT > 1) && mem_q.mem_read) begin
               state_d = ST_MEM_WAIT;
               wcnt_d  = '0;
            end
         end
         ST_MEM_WAIT: begin
            if (wcnt_q == WAIT_LAST) state_d = ST_RUN;
            else                     wcnt_d  = wcnt_q + 1'b1;
         end
         default: state_d = ST_RUN;
      endcase
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk     (clk),
      .reset   (reset),
      .inc_i   (pc_stall_o),
      .clear_i (1'b0),
      .value_o (stall_cnt_o)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk     (clk),
      .reset   (reset),
      .inc_i   (redir),
      .clear_i (1'b0),
      .value_o (flush_cnt_o)
   );

   // Shadow fields kept for completeness but not consumed downstream
   logic unused_shadow;
   assign unused_shadow = ^{mem_q.rs1, mem_q.rs2, wb_q.rs1, wb_q.rs2, wb_q.mem_read};

endmodule
